// File: rtl/tt_vec_wb_pkg.sv
// Shared types for the vector writeback/merge stage.
// Request payload layout, element-width encoding and per-byte merge select.
package tt_vec_wb_pkg;

  localparam int WB_VLEN = 128;
  localparam int WB_VLW  = $clog2(WB_VLEN/8) + 1;

  typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW64} sew_e;

  typedef enum logic [1:0] {SEL_NEW, SEL_OLD, SEL_ONES} bsel_e;

  // Payload width is fixed by WB_VLEN; the top's VLEN must match it.
  typedef struct packed {
    logic [4:0]         vd;
    logic [WB_VLEN-1:0] data;
    sew_e               sew;
    logic [WB_VLW-1:0]  vl;
    logic               vm;
    logic               vta;
    logic               vma;
  } wb_req_t;

  function automatic logic [3:0] sew_bytes(sew_e s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/tt_vec_wb_bytemask.sv
// Per-byte merge select: new result byte, old destination byte, or all-ones,
// from element width, vl, v0 masking and the tail/mask agnostic policies.
module tt_vec_wb_bytemask
  import tt_vec_wb_pkg::*;
#(
  parameter int VLEN = WB_VLEN,
  parameter int VLW  = $clog2(VLEN/8) + 1
) (
  input  logic [1:0]                    sew,
  input  logic [VLW-1:0]                vl,
  input  logic                          vm,
  input  logic [VLEN-1:0]               v0,
  input  logic                          vta,
  input  logic                          vma,
  output logic [VLEN/8-1:0][1:0]        sel
);

  localparam int NB = VLEN/8;
  localparam int IW = $clog2(VLEN);

  // Body ends at byte vl*sew_bytes; an oversized vl simply covers every byte.
  logic [VLW+3:0] lim;
  assign lim = (VLW+4)'(vl) * (VLW+4)'(sew_bytes(sew_e'(sew)));

  for (genvar b = 0; b < NB; b++) begin : g_byte
    logic [IW-1:0] eidx;
    logic          body, active;
    assign eidx   = IW'(b) >> sew;
    assign body   = (VLW+4)'(b) < lim;
    assign active = body & (vm | v0[eidx]);
    assign sel[b] = active ? SEL_NEW : ((body ? vma : vta) ? SEL_ONES : SEL_OLD);
  end

endmodule

// File: rtl/tt_vec_wb_merge.sv
// Vector writeback: round-robin ALU/LD arbitration into S1, then merge with the
// destination's old contents and v0, one full register write per cycle.
module tt_vec_wb_merge
  import tt_vec_wb_pkg::*;
#(
  parameter int VLEN = WB_VLEN,
  parameter int VLW  = $clog2(VLEN/8) + 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_alu_vld,
  output logic            o_alu_rdy,
  input  logic [4:0]      i_alu_vd,
  input  logic [VLEN-1:0] i_alu_data,
  input  logic [1:0]      i_alu_sew,
  input  logic [VLW-1:0]  i_alu_vl,
  input  logic            i_alu_vm,
  input  logic            i_alu_vta,
  input  logic            i_alu_vma,
  input  logic            i_ld_vld,
  output logic            o_ld_rdy,
  input  logic [4:0]      i_ld_vd,
  input  logic [VLEN-1:0] i_ld_data,
  input  logic [1:0]      i_ld_sew,
  input  logic [VLW-1:0]  i_ld_vl,
  input  logic            i_ld_vm,
  input  logic            i_ld_vta,
  input  logic            i_ld_vma,
  input  logic            i_stall,
  input  logic [VLEN-1:0] i_old_data,
  input  logic [VLEN-1:0] i_v0,
  output logic            o_wren,
  output logic [4:0]      o_wraddr,
  output logic [VLEN-1:0] o_wrdata,
  output logic            o_pend_vld,
  output logic [4:0]      o_pend_vd,
  output logic [31:0]     o_wr_cnt
);

  localparam int NB = VLEN/8;

  wb_req_t               s1, req_in;
  logic                  s1_vld, rr_ld;
  logic                  advance, can_load, gnt_alu, gnt_ld;
  logic [NB-1:0][1:0]    sel;
  logic [VLEN-1:0]       merged;

  assign advance  = s1_vld & ~i_stall;
  assign can_load = ~s1_vld | advance;
  // rr_ld=1 means LD has priority on the next contended cycle.
  assign gnt_alu  = can_load & i_alu_vld & (~i_ld_vld | ~rr_ld);
  assign gnt_ld   = can_load & i_ld_vld & (~i_alu_vld | rr_ld);
  assign o_alu_rdy = gnt_alu;
  assign o_ld_rdy  = gnt_ld;

  always_comb begin
    req_in = '{vd: i_alu_vd, data: i_alu_data, sew: sew_e'(i_alu_sew), vl: i_alu_vl,
               vm: i_alu_vm, vta: i_alu_vta, vma: i_alu_vma};
    if (gnt_ld)
      req_in = '{vd: i_ld_vd, data: i_ld_data, sew: sew_e'(i_ld_sew), vl: i_ld_vl,
                 vm: i_ld_vm, vta: i_ld_vta, vma: i_ld_vma};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_vld   <= 1'b0;
      s1       <= '0;
      rr_ld    <= 1'b0;
      o_wr_cnt <= '0;
    end else begin
      if (can_load)         s1_vld <= gnt_alu | gnt_ld;
      if (gnt_alu | gnt_ld) s1     <= req_in;
      if (gnt_alu)          rr_ld  <= 1'b1;
      else if (gnt_ld)      rr_ld  <= 1'b0;
      if (advance)          o_wr_cnt <= o_wr_cnt + 32'd1;
    end
  end

  tt_vec_wb_bytemask #(.VLEN(VLEN), .VLW(VLW)) u_bytemask (
    .sew (s1.sew),
    .vl  (s1.vl),
    .vm  (s1.vm),
    .v0  (i_v0),
    .vta (s1.vta),
    .vma (s1.vma),
    .sel (sel)
  );

  for (genvar b = 0; b < NB; b++) begin : g_merge
    assign merged[8*b +: 8] = (sel[b] == SEL_NEW)  ? s1.data[8*b +: 8] :
                              (sel[b] == SEL_ONES) ? 8'hFF : i_old_data[8*b +: 8];
  end

  // Address is driven for the whole S1 residency so the regfile can return old data.
  assign o_wren     = advance;
  assign o_wraddr   = s1_vld ? s1.vd : 5'd0;
  assign o_wrdata   = s1_vld ? merged : '0;
  assign o_pend_vld = s1_vld;
  assign o_pend_vd  = o_wraddr;

endmodule
